// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared constants and types for the BCD conversion blocks (bcd_to_bin and
// the combinational to_bcd converter).
//   DIGIT_W        : bits per packed BCD digit
//   BCD_MAX_DIGIT  : largest legal decimal digit value
//   DEF_NDIGITS    : default number of BCD digits in an operand word
//   DEF_BIN_W      : default binary width, wide enough for 10^DEF_NDIGITS - 1
//   conv_state_e   : sequencer states of the serial BCD-to-binary converter
// ----------------------------------------------------------------------------
package bcd_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

   localparam int DEF_NDIGITS = 5;
   localparam int DEF_BIN_W   = 17;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } conv_state_e;

endpackage

// File: rtl/bcd_mac10.sv
// ----------------------------------------------------------------------------
// bcd_mac10
// Combinational multiply-by-ten-and-add step used to fold one decimal digit
// into a binary accumulator.
// Ports:
//   acc       (in,  BIN_W)   running binary value
//   digit     (in,  DIGIT_W) next decimal digit, most significant first
//   acc_next  (out, BIN_W)   acc*10 + digit, truncated to BIN_W
//   digit_err (out, 1)       digit is not a legal decimal digit (> 9)
// ----------------------------------------------------------------------------
module bcd_mac10
   import bcd_pkg::*;
#(
   parameter int BIN_W = DEF_BIN_W
) (
   input  logic [BIN_W-1:0]   acc,
   input  logic [DIGIT_W-1:0] digit,
   output logic [BIN_W-1:0]   acc_next,
   output logic               digit_err
);

   logic [BIN_W+3:0] acc_wide;
   logic [BIN_W+3:0] prod;
   logic [3:0]       unused_hi;

   // The times-ten is built from two shifts so no multiplier is inferred.
   // Working four bits wider keeps the intermediate exact; for legal digit
   // strings the upper bits are always zero, so truncation loses nothing.
   // Illegal digits still add their raw value, which the caller flags.
   assign acc_wide  = {4'b0000, acc};
   assign prod      = (acc_wide << 3) + (acc_wide << 1) + {{BIN_W{1'b0}}, digit};
   assign {unused_hi, acc_next} = prod;

   assign digit_err = (digit > BCD_MAX_DIGIT);

endmodule

// File: rtl/bcd_to_bin.sv
// ----------------------------------------------------------------------------
// bcd_to_bin
// Serial BCD-to-binary converter: folds one digit per clock into an
// accumulator, most significant digit first, and reports illegal digits.
// Ports:
//   clk     (in,  1)           system clock, rising edge
//   rst_n   (in,  1)           asynchronous active-low reset
//   start   (in,  1)           conversion request, honoured only when idle
//   bcd_in  (in,  4*NDIGITS)   packed BCD operand, top digit in the MSBs
//   busy    (out, 1)           conversion in progress (CONV or DONE)
//   done    (out, 1)           one-cycle pulse, bin_out/err valid
//   bin_out (out, BIN_W)       last converted value, held between conversions
//   err     (out, 1)           last conversion contained a digit above 9
// ----------------------------------------------------------------------------
module bcd_to_bin
   import bcd_pkg::*;
#(
   parameter int NDIGITS = DEF_NDIGITS,
   parameter int BIN_W   = DEF_BIN_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [DIGIT_W*NDIGITS-1:0]   bcd_in,
   output logic                         busy,
   output logic                         done,
   output logic [BIN_W-1:0]             bin_out,
   output logic                         err
);

   localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIGITS - 1);

   conv_state_e                  state_q;
   conv_state_e                  state_d;
   logic [DIGIT_W*NDIGITS-1:0]   digits_q;
   logic [BIN_W-1:0]             acc_q;
   logic                         err_acc_q;
   logic [CNT_W-1:0]             cnt_q;
   logic [BIN_W-1:0]             mac_acc;
   logic                         mac_err;
   logic                         last_digit;

   assign last_digit = (cnt_q == LAST_CNT);

   // One digit step per clock; the top nibble of the shift register is
   // always the digit being folded in this cycle.
   bcd_mac10 #(
      .BIN_W (BIN_W)
   ) u_mac10 (
      .acc       (acc_q),
      .digit     (digits_q[DIGIT_W*NDIGITS-1 -: DIGIT_W]),
      .acc_next  (mac_acc),
      .digit_err (mac_err)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Start is only looked at in IDLE, so requests that
   // arrive during CONV or DONE are dropped rather than queued; a held start
   // naturally re-triggers on the first idle cycle after DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CONV;
         CONV:    if (last_digit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath. The operand is captured once at start so later bcd_in changes
   // cannot corrupt a conversion. On the final digit the result registers are
   // loaded straight from the MAC output, so bin_out/err are already valid in
   // the DONE cycle and otherwise hold their value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_q  <= '0;
         acc_q     <= '0;
         err_acc_q <= 1'b0;
         cnt_q     <= '0;
         bin_out   <= '0;
         err       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  digits_q  <= bcd_in;
                  acc_q     <= '0;
                  err_acc_q <= 1'b0;
                  cnt_q     <= '0;
               end
            end
            CONV: begin
               acc_q     <= mac_acc;
               err_acc_q <= err_acc_q | mac_err;
               digits_q  <= digits_q << DIGIT_W;
               cnt_q     <= cnt_q + CNT_W'(1);
               if (last_digit) begin
                  bin_out <= mac_acc;
                  err     <= err_acc_q | mac_err;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status flags decoded from the registered state only.
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Sequential BCD-to-binary converter. It is the inverse of the combinational to_bcd binary-to-BCD converter.
- Takes a packed NDIGITS-digit BCD word and produces an unsigned binary value using an iterative multiply-by-10-and-add, one digit per clock, most-significant digit first.
- Sits on the operand-entry path: decimal operands from keypad or host are converted here before feeding the signed 8x8 SPM datapath. Also used for BCD round-trip checks.

Parameters:
- NDIGITS, 5, number of BCD digits in bcd_in.
- BIN_W, 17, width of bin_out. Must satisfy 2^BIN_W > 10^NDIGITS - 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bcd_in  input  4*NDIGITS  packed BCD; digit NDIGITS-1 in the MSBs.
- busy  output  1  high while a conversion is in progress (CONV or DONE).
- done  output  1  one-cycle pulse; bin_out and err are valid while it is high.
- bin_out  output  BIN_W  converted value; holds until the next completed conversion.
- err  output  1  at least one digit of the last conversion was greater than 9; updates with done.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, bin_out=0, err=0; accumulator, digit shift register and counter all cleared.
- Reset mid-conversion aborts the conversion. No done pulse is produced, and bin_out/err return to 0.
- IDLE:
  - start=1 at an edge loads bcd_in into the digit shift register, clears acc, err_acc and cnt, and moves to CONV.
  - bcd_in is sampled only at that edge; later changes are ignored.
- CONV: on each edge,
  - acc <= acc*10 + d, where d is the top digit of the shift register. Implement *10 as (acc<<3)+(acc<<1), computed at BIN_W+4 bits, then truncated to BIN_W. This cannot overflow for legal inputs.
  - err_acc |= (d > 9). An illegal digit still contributes its raw value to acc.
  - Shift the digit register left by 4 and increment cnt.
  - When cnt reaches NDIGITS-1, the same edge registers bin_out <= final acc and err <= final err_acc, then moves to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- Latency:
  - start sampled at edge E0; done high in the cycle following edge E_NDIGITS (E5 by default).
  - Back-to-back throughput is one conversion per NDIGITS+2 cycles.
- Handshake:
  - start while busy=1 (CONV or DONE) is ignored, with no queueing.
  - start held continuously re-triggers in the first IDLE cycle after DONE.
- busy = (state != IDLE), driven from registered state.
- bin_out and err never change except on the conversion-complete edge or on reset.
- Digit value 0 in every position gives bin_out=0 with err=0. Leading zeros are legal.

Decomposition:
- bcd_pkg holds:
  - DIGIT_W=4 and BCD_MAX_DIGIT=9.
  - The state enum encoding IDLE=2'd0, CONV=2'd1, DONE=2'd2.
  - The default NDIGITS/BIN_W constants, shared with to_bcd.
- One sub-module is natural: bcd_mac10. It is combinational: acc, digit -> acc*10+digit, plus the digit>9 flag. It is reusable by a future serial BCD accumulator.
- The FSM, counter and shift register stay in bcd_to_bin.

Test Plan:
- Reset, then start with bcd_in=20'h12345 -> busy=1 from the next cycle; done pulses exactly one cycle after edge E5; bin_out=12345, err=0.
- bcd_in=20'h99999 -> bin_out=99999 (17'h1869F), err=0.
- bcd_in=20'h1A000 -> done pulses; err=1; bin_out=10*10000+1*... raw value 20000 (digits 1,10,0,0,0), compared exactly.
- Pulse start at 20'h00128, then pulse start again at 20'h00045 two cycles later -> the second start is ignored; bin_out=128; exactly one done pulse.
- Start with 20'h54321, assert rst_n=0 at edge E3 -> outputs go to 0 immediately with no done pulse. After release, a new start with 20'h09999 -> bin_out=9999.
- Round trip: for bin values 0, 9, 45, 123, 999, 1234, 9999, 32767, drive to_bcd, zero-extend its output to 5 digits, and convert -> bin_out equals the original value, err=0 in all cases.
